// File: rtl/cordic_pkg.sv
// cordic_pkg: constants shared by the CORDIC rotation and vectoring engines.
// Angles are Q2.14 radians; datapath x/y are 19 bits and z is Q4.14.
package cordic_pkg;

  localparam int FRAC_BITS = 14;
  localparam int LENGTH    = 8;
  localparam int XW        = 19;
  localparam int ZW        = 18;
  localparam int IW        = $clog2(LENGTH);

  localparam logic signed [15:0] GAIN    = 16'sd9949;
  localparam logic signed [15:0] HALF_PI = 16'sd25736;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_SCALE
  } state_e;

  // round(atan(2^-i) * 2^14)
  function automatic logic signed [15:0] atan_lut(input int i);
    case (i)
      0:       atan_lut = 16'sd12868;
      1:       atan_lut = 16'sd7596;
      2:       atan_lut = 16'sd4014;
      3:       atan_lut = 16'sd2037;
      4:       atan_lut = 16'sd1023;
      5:       atan_lut = 16'sd512;
      6:       atan_lut = 16'sd256;
      7:       atan_lut = 16'sd128;
      8:       atan_lut = 16'sd64;
      9:       atan_lut = 16'sd32;
      10:      atan_lut = 16'sd16;
      11:      atan_lut = 16'sd8;
      12:      atan_lut = 16'sd4;
      13:      atan_lut = 16'sd2;
      14:      atan_lut = 16'sd1;
      default: atan_lut = 16'sd0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_microrot.sv
// cordic_microrot: one combinational CORDIC micro-rotation.
// pos=1 rotates clockwise (vectoring: y>=0, rotation: z<0).
module cordic_microrot
  import cordic_pkg::*;
(
  input  logic signed [XW-1:0] x,
  input  logic signed [XW-1:0] y,
  input  logic signed [ZW-1:0] z,
  input  logic        [IW-1:0] shift,
  input  logic signed [15:0]   atan,
  input  logic                 pos,
  output logic signed [XW-1:0] x_nx,
  output logic signed [XW-1:0] y_nx,
  output logic signed [ZW-1:0] z_nx
);

  logic signed [XW-1:0] xs;
  logic signed [XW-1:0] ys;
  logic signed [ZW-1:0] a;

  assign xs = x >>> shift;
  assign ys = y >>> shift;
  assign a  = ZW'(atan);

  assign x_nx = pos ? x + ys : x - ys;
  assign y_nx = pos ? y - xs : y + xs;
  assign z_nx = pos ? z + a  : z - a;

endmodule

// File: rtl/cordic_vectoring_iterative.sv
// cordic_vectoring_iterative: atan2 phase and scaled magnitude of (x, y),
// one micro-rotation per clock after a quadrant pre-rotation.
module cordic_vectoring_iterative
  import cordic_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] phase,
  output logic [15:0] magnitude
);

  state_e state_q, state_d;

  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic signed [XW-1:0] x_nx, y_nx, xi, yi;
  logic signed [ZW-1:0] z_q, z_d, z_nx, hp;
  logic        [IW-1:0] i_q, i_d;
  logic                 zero_q, zero_d;
  logic                 done_q, done_d;
  logic        [15:0]   phase_q, phase_d;
  logic        [15:0]   mag_q, mag_d;
  logic signed [XW+15:0] prod;
  logic signed [XW+1:0]  mag_full;

  assign xi = XW'($signed(x_in));
  assign yi = XW'($signed(y_in));
  assign hp = ZW'(HALF_PI);

  cordic_microrot u_rot (
    .x     (x_q),
    .y     (y_q),
    .z     (z_q),
    .shift (i_q),
    .atan  (atan_lut(int'(i_q))),
    .pos   (~y_q[XW-1]),
    .x_nx  (x_nx),
    .y_nx  (y_nx),
    .z_nx  (z_nx)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    i_d      = i_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    phase_d  = phase_q;
    mag_d    = mag_q;
    prod     = (XW+16)'(x_q) * (XW+16)'(GAIN);
    mag_full = (XW+2)'(prod >>> FRAC_BITS);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ITER;
          i_d     = '0;
          zero_d  = (x_in == 16'd0) && (y_in == 16'd0);
          // fold left half-plane into the right so the iterations converge
          if (!xi[XW-1]) begin
            x_d = xi;
            y_d = yi;
            z_d = '0;
          end else if (!yi[XW-1]) begin
            x_d = yi;
            y_d = -xi;
            z_d = hp;
          end else begin
            x_d = -yi;
            y_d = xi;
            z_d = -hp;
          end
        end
      end
      ST_ITER: begin
        x_d = x_nx;
        y_d = y_nx;
        z_d = z_nx;
        i_d = i_q + IW'(1);
        if (i_q == IW'(LENGTH-1)) state_d = ST_SCALE;
      end
      ST_SCALE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (zero_q || mag_full[XW+1]) mag_d = '0;
        else if (|mag_full[XW:15])    mag_d = 16'h7fff;
        else                          mag_d = mag_full[15:0];
        phase_d = zero_q ? '0 : 16'(z_q >>> 1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      phase_q <= '0;
      mag_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      phase_q <= phase_d;
      mag_q   <= mag_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign phase     = phase_q;
  assign magnitude = mag_q;

endmodule

// File: tb/tb_cordic_vectoring_iterative.sv
// tb_cordic_vectoring_iterative: directed table, random vectors against a
// real-arithmetic atan2/hypot model, and handshake/reset corner sequences.
module tb_cordic_vectoring_iterative;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] x_in;
  logic [15:0] y_in;
  logic        busy;
  logic        done;
  logic [15:0] phase;
  logic [15:0] magnitude;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  cordic_vectoring_iterative dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .phase     (phase),
    .magnitude (magnitude)
  );

  typedef struct {
    int x;
    int y;
    int ph;
    int mg;
    int pt;
    int mt;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input bit ok,
                     input int act, input int exp);
    nvec++;
    if (!ok) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int wrapd(input int d);
    int r;
    r = d;
    if (r > 25736)  r -= 51472;
    if (r < -25736) r += 51472;
    return r;
  endfunction

  task automatic model(input int xv, input int yv,
                       output int ph, output int mg);
    real a;
    real m;
    if (xv == 0 && yv == 0) begin
      ph = 0;
      mg = 0;
    end else begin
      a  = $atan2(real'(yv), real'(xv));
      m  = $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv));
      ph = int'(a * 8192.0);
      mg = int'(m);
      if (mg > 32767) mg = 32767;
    end
  endtask

  task automatic convert(input int xv, input int yv, input bit hammer,
                         output int ph, output int mg, output int ncyc,
                         output logic dn_fall, output logic dn_after);
    @(negedge clk);
    x_in  = 16'(xv);
    y_in  = 16'(yv);
    start = 1'b1;
    @(negedge clk);
    start = hammer;
    ncyc  = 0;
    while (busy && ncyc < 30) begin
      x_in = 16'($urandom);
      y_in = 16'($urandom);
      @(negedge clk);
      ncyc++;
    end
    start    = 1'b0;
    dn_fall  = done;
    ph       = int'($signed(phase));
    mg       = int'($signed(magnitude));
    @(negedge clk);
    dn_after = done;
  endtask

  task automatic run_chk(input string nm, input int xv, input int yv,
                         input bit hammer, input int eph, input int emg,
                         input int pt, input int mt);
    int   ph, mg, ncyc, d;
    logic df, da;
    convert(xv, yv, hammer, ph, mg, ncyc, df, da);
    chk({nm, " busy cycles"}, ncyc == 9, ncyc, 9);
    chk({nm, " done pulse"}, df && !da, int'({df, da}), 2);
    d = wrapd(ph - eph);
    chk({nm, " phase"}, d <= pt && d >= -pt, ph, eph);
    chk({nm, " magnitude"}, (mg - emg) <= mt && (emg - mg) <= mt, mg, emg);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    tbl[0] = '{16384, 0, 0, 16384, 80, 164};
    tbl[1] = '{11585, 11585, 6434, 16384, 80, 164};
    tbl[2] = '{0, -16384, -12868, 16384, 80, 164};
    tbl[3] = '{-16384, 0, 25736, 16384, 80, 164};
    tbl[4] = '{-11585, -11585, -19302, 16384, 80, 164};
    tbl[5] = '{0, 0, 0, 0, 0, 0};
    tbl[6] = '{-32768, -32768, -19302, 32767, 80, 0};

    repeat (3) @(negedge clk);
    chk("reset busy", busy == 1'b0, int'(busy), 0);
    chk("reset done", done == 1'b0, int'(done), 0);
    chk("reset phase", phase == 16'd0, int'(phase), 0);
    chk("reset magnitude", magnitude == 16'd0, int'(magnitude), 0);
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++) begin
      run_chk($sformatf("table%0d", k), tbl[k].x, tbl[k].y, 1'b0,
              tbl[k].ph, tbl[k].mg, tbl[k].pt, tbl[k].mt);
    end

    for (int k = 0; k < 40; k++) begin
      int xv, yv, eph, emg;
      do begin
        xv = int'($signed(16'($urandom)));
        yv = int'($signed(16'($urandom)));
      end while (xv * xv + yv * yv < 4096 * 4096);
      model(xv, yv, eph, emg);
      run_chk($sformatf("rand%0d", k), xv, yv, 1'b0,
              eph, emg, 80, emg / 100 + 2);
    end

    begin
      int eph, emg;
      model(11585, 11585, eph, emg);
      run_chk("start during busy", 11585, 11585, 1'b1,
              eph, emg, 80, 164);
      repeat (6) begin
        x_in = 16'($urandom);
        y_in = 16'($urandom);
        @(negedge clk);
      end
      chk("hold busy", busy == 1'b0, int'(busy), 0);
      chk("hold done", done == 1'b0, int'(done), 0);
      chk("hold phase", wrapd(int'($signed(phase)) - eph) <= 80 &&
          wrapd(int'($signed(phase)) - eph) >= -80,
          int'($signed(phase)), eph);
      chk("hold magnitude", int'(magnitude) - emg <= 164 &&
          emg - int'(magnitude) <= 164, int'(magnitude), emg);
    end

    @(negedge clk);
    x_in  = 16'd16384;
    y_in  = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-abort busy", busy == 1'b1, int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", busy == 1'b0, int'(busy), 0);
    chk("abort phase", phase == 16'd0, int'($signed(phase)), 0);
    chk("abort magnitude", magnitude == 16'd0, int'(magnitude), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-abort busy", busy == 1'b0, int'(busy), 0);
    chk("post-abort done", done == 1'b0, int'(done), 0);
    run_chk("after abort", -16384, 0, 1'b0, 25736, 16384, 80, 164);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
